sha_nonce_dispatch: RTL and testbench
=====================================

Name: sha_nonce_dispatch

Overview:
- Multi-lane nonce/time generator and solution recovery unit feeding LANES parallel sha_hasher pipelines.
- Issues a contiguous 64-bit {time,nonce} window each cycle; nonce overflow carries into time.
- Maps each delayed per-lane target hit back to the exact {time,nonce} that produced it, replacing sha_hasher's missing rollback.
- Buffers solutions in a small FIFO with a valid/ready handshake toward the host interface.

Parameters:
LANES, 4, number of parallel hasher lanes (1..16); per-cycle counter stride
LATENCY, 130, cycles from a lane's nonce being presented to its lane_hit for that nonce (>=1)
FIFO_DEPTH, 4, solution FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
load  in  1  sample time_in/nonce_in as new search base; restart search
time_in  in  32  starting time word
nonce_in  in  32  starting nonce
active  out  1  lane outputs are valid and the search is running
lane_time  out  32*LANES  time word for lane i at bits [32i+31:32i]
lane_nonce  out  32*LANES  nonce for lane i at bits [32i+31:32i]
lane_hit  in  LANES  per-lane target met, aligned LATENCY cycles after issue
sol_valid  out  1  solution FIFO non-empty
sol_ready  in  1  consumer accepts head entry
sol_time  out  32  time word of head solution
sol_nonce  out  32  nonce of head solution
sol_lane  out  4  lane index of head solution
drop_count  out  8  saturating count of discarded hits

Behaviour:
- Reset: base=0, active=0, warm=0, FIFO empty, sol_valid=0, sol_* outputs 0, drop_count=0. lane_* = 0+i (don't-care while active=0).
- State: 64-bit base={time,nonce}; warm counter 0..LATENCY; active flag.
- load (RST=0): base <= {time_in,nonce_in}; active <= 1; warm <= 0. FIFO and drop_count are kept.
- Each cycle with active=1 and no load: base <= base + LANES (mod 2^64); warm <= min(warm+1, LATENCY).
- Lane outputs are combinational from base: {lane_time_i,lane_nonce_i} = base + i in 64-bit arithmetic, so the carry from nonce into time is per lane.
- Example: base nonce FFFFFFFE with LANES=4 gives lane 2 = {time+1, 00000000}.
- Cycle numbering: cycle 0 is the first cycle after the load edge.
- Hit qualification: lane_hit is honoured only when active=1, warm==LATENCY and load=0. Otherwise the hit is silently ignored and drop_count is not touched.
- Rollback: a hit on lane i in cycle k refers to the issue in cycle k-LATENCY. The recovered value is base_k - LATENCY*LANES + i (64-bit, mod 2^64). The constant is computed at elaboration.
- Multiple hits in one cycle: the lowest set lane is enqueued. drop_count += popcount-1, saturating at FF.
- FIFO push: at the edge after a qualified hit. sol_valid rises 1 cycle after the hit cycle when the FIFO was empty.
- FIFO full: the hit is dropped and drop_count += popcount, unless a pop occurs in the same cycle. Simultaneous push and pop on a full FIFO is legal; the push is accepted.
- Pop: at the edge where sol_valid & sol_ready. sol_* always present the head entry; order is FIFO.
- Load mid-run: the warm-up restarts, so in-flight hits from the old window are ignored for LATENCY cycles. Queued solutions remain.
- RST mid-operation: everything returns to reset values on that edge, FIFO flushed.
- 64-bit wrap of {FFFFFFFF,FFFFFFFF} to 0 is silent.

Test Plan:
All scenarios use LANES=4, LATENCY=8, FIFO_DEPTH=4.
1. Hold RST=1 with random inputs -> active=0, sol_valid=0, drop_count=00, sol_* = 0.
2. Carry into time:
   - Stimulus: load time=AAAAAAA1, nonce=FFFFFFF0.
   - Cycle 3 -> lane0..3 nonce FFFFFFFC..FFFFFFFF, time AAAAAAA1.
   - Cycle 4 -> lane0 = {AAAAAAA2, 00000000}, lane3 nonce 00000003.
3. Rollback:
   - Stimulus: load time=130dae51, nonce=3aeb9bb0; lane_hit=4'b0001 in cycle 10.
   - Cycle 11 -> sol_valid=1, sol_time=130dae51, sol_nonce=3aeb9bb8, sol_lane=0.
   - sol_ready=1 -> sol_valid falls next cycle.
4. Warm-up gating:
   - Same load as scenario 3; lane_hit=4'b1111 in cycle 7 -> no sol_valid, drop_count=00.
   - Hit in cycle 8 on lane 3 -> sol_nonce=3aeb9bb3.
5. Multi-hit: lane_hit=4'b1010 in cycle 8 -> one entry with sol_lane=1, sol_nonce=3aeb9bb1; drop_count=01.
6. FIFO full and ordering:
   - Stimulus: sol_ready=0; single hits on lane 0 in cycles 8..12.
   - Required: FIFO holds nonces 3aeb9bb0, b4, b8, bc; drop_count=01.
   - Then sol_ready=1 -> entries pop in that order, one per cycle.
   - A push in the same cycle as a pop on the full FIFO is accepted.

Source files
------------

// File: rtl/sha_nonce_dispatch.sv
// Nonce/time window generator for LANES parallel hashers, with delayed-hit rollback
// to the exact {time,nonce} that produced the hit and a small solution FIFO.
module sha_nonce_dispatch #(
    parameter int LANES      = 4,
    parameter int LATENCY    = 130,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [31:0]           time_in,
    input  logic [31:0]           nonce_in,
    output logic                  active,
    output logic [32*LANES-1:0]   lane_time,
    output logic [32*LANES-1:0]   lane_nonce,
    input  logic [LANES-1:0]      lane_hit,
    output logic                  sol_valid,
    input  logic                  sol_ready,
    output logic [31:0]           sol_time,
    output logic [31:0]           sol_nonce,
    output logic [3:0]            sol_lane,
    output logic [7:0]            drop_count
);

    localparam int WW = $clog2(LATENCY + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [WW-1:0] WARM_MAX = WW'(LATENCY);
    localparam logic [63:0]   ROLLBACK = 64'(LATENCY) * 64'(LANES);
    localparam logic [63:0]   STRIDE   = 64'(LANES);

    logic [63:0]   base;
    logic [WW-1:0] warm;

    logic [67:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          qualified;
    logic          full;
    logic          push;
    logic          pop;
    logic [3:0]    hit_lane;
    logic [4:0]    hit_count;
    logic [4:0]    drop_inc;
    logic [8:0]    drop_sum;
    logic [63:0]   recovered;
    logic [67:0]   head;

    // Carry from nonce into time is resolved independently for every lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [63:0] lane_val;
        assign lane_val = base + 64'(gi);
        assign lane_time[32*gi +: 32]  = lane_val[63:32];
        assign lane_nonce[32*gi +: 32] = lane_val[31:0];
    end

    always_comb begin
        hit_lane  = '0;
        hit_count = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                hit_lane = 4'(i);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            hit_count = hit_count + 5'(lane_hit[i]);
        end
    end

    assign sol_valid = (count != '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop       = sol_valid && sol_ready;
    assign qualified = active && (warm == WARM_MAX) && !load && (|lane_hit);
    assign push      = qualified && (!full || pop);
    assign recovered = base - ROLLBACK + 64'(hit_lane);

    always_comb begin
        drop_inc = '0;
        if (qualified) begin
            drop_inc = push ? (hit_count - 5'd1) : hit_count;
        end
        drop_sum = 9'(drop_count) + 9'(drop_inc);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            base       <= '0;
            warm       <= '0;
            active     <= 1'b0;
            drop_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (load) begin
                base   <= {time_in, nonce_in};
                active <= 1'b1;
                warm   <= '0;
            end else if (active) begin
                base <= base + STRIDE;
                if (warm != WARM_MAX) begin
                    warm <= warm + WW'(1);
                end
            end

            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= {hit_lane, recovered};
        end
    end

    assign head      = mem[rd_ptr];
    assign sol_lane  = sol_valid ? head[67:64] : 4'd0;
    assign sol_time  = sol_valid ? head[63:32] : 32'd0;
    assign sol_nonce = sol_valid ? head[31:0]  : 32'd0;

endmodule

// File: tb/tb_sha_nonce_dispatch.sv
// Randomized + directed bench for sha_nonce_dispatch against a behavioural model that
// remembers every issued window and looks up the one LATENCY cycles back.
module tb_sha_nonce_dispatch;

    localparam int LANES = 4;
    localparam int LAT   = 8;
    localparam int DEPTH = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic                load;
    logic [31:0]         time_in;
    logic [31:0]         nonce_in;
    logic                active;
    logic [32*LANES-1:0] lane_time;
    logic [32*LANES-1:0] lane_nonce;
    logic [LANES-1:0]    lane_hit;
    logic                sol_valid;
    logic                sol_ready;
    logic [31:0]         sol_time;
    logic [31:0]         sol_nonce;
    logic [3:0]          sol_lane;
    logic [7:0]          drop_count;

    sha_nonce_dispatch #(
        .LANES(LANES),
        .LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .load(load),
        .time_in(time_in),
        .nonce_in(nonce_in),
        .active(active),
        .lane_time(lane_time),
        .lane_nonce(lane_nonce),
        .lane_hit(lane_hit),
        .sol_valid(sol_valid),
        .sol_ready(sol_ready),
        .sol_time(sol_time),
        .sol_nonce(sol_nonce),
        .sol_lane(sol_lane),
        .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  lane;
        logic [63:0] val;
    } sol_t;

    // Model state: current window, cycle index since load, history of issued windows.
    logic [63:0] m_base;
    bit          m_active;
    bit          m_rstd;
    int          m_cyc;
    int          m_drop;
    logic [63:0] hist[$];
    sol_t        q[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("active", 64'(active), 64'(m_active));
        if (m_active || m_rstd) begin
            for (int i = 0; i < LANES; i++) begin
                checkOutput($sformatf("lane%0d", i),
                            {lane_time[32*i +: 32], lane_nonce[32*i +: 32]}, m_base + 64'(i));
            end
        end
        checkOutput("sol_valid", 64'(sol_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            checkOutput("sol_time", 64'(sol_time), 64'(q[0].val[63:32]));
            checkOutput("sol_nonce", 64'(sol_nonce), 64'(q[0].val[31:0]));
            checkOutput("sol_lane", 64'(sol_lane), 64'(q[0].lane));
        end else if (m_rstd) begin
            checkOutput("rst_sol", {sol_time, sol_nonce}, 64'd0);
            checkOutput("rst_lane", 64'(sol_lane), 64'd0);
        end
        checkOutput("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic modelUpdate(input bit r, input bit l, input logic [31:0] t, input logic [31:0] n,
                               input logic [3:0] h, input bit rdy);
        bit   pop;
        bit   do_push;
        int   lowest;
        int   inc;
        sol_t s;
        if (r) begin
            m_base = '0; m_active = 0; m_cyc = 0; m_drop = 0; m_rstd = 1;
            hist.delete(); q.delete();
        end else begin
            m_rstd  = 0;
            pop     = (q.size() > 0) && rdy;
            do_push = 0;
            if (m_active && m_cyc >= LAT && !l && h != 0) begin
                lowest = -1;
                for (int i = LANES - 1; i >= 0; i--) if (h[i]) lowest = i;
                s.lane = 4'(lowest);
                s.val  = hist[m_cyc - LAT] + 64'(lowest);
                if (q.size() < DEPTH || pop) begin
                    do_push = 1;
                    inc = $countones(h) - 1;
                end else begin
                    inc = $countones(h);
                end
                m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
            end
            if (pop) void'(q.pop_front());
            if (do_push) q.push_back(s);
            if (l) begin
                m_base = {t, n}; m_active = 1; m_cyc = 0;
                hist.delete(); hist.push_back(m_base);
            end else if (m_active) begin
                m_base = m_base + 64'(LANES); m_cyc++;
                hist.push_back(m_base);
            end
        end
    endtask

    // One clock: drive at the falling edge, check state, then advance DUT and model together.
    task automatic applyStimulus(input bit r, input bit l, input logic [31:0] t, input logic [31:0] n,
                                 input logic [3:0] h, input bit rdy);
        RST = r; load = l; time_in = t; nonce_in = n; lane_hit = h; sol_ready = rdy;
        #1;
        checkAll();
        @(posedge CLK);
        modelUpdate(r, l, t, n, h, rdy);
        @(negedge CLK);
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, $urandom, $urandom, 4'h0, rdy);
    endtask

    task automatic doLoad(input logic [31:0] t, input logic [31:0] n);
        applyStimulus(0, 1, t, n, 4'h0, 0);
    endtask

    initial begin
        RST = 1; load = 0; time_in = 0; nonce_in = 0; lane_hit = 0; sol_ready = 0;
        @(posedge CLK);
        modelUpdate(1, 0, 0, 0, 0, 0);
        @(negedge CLK);

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom));
        checkOutput("s1_active", 64'(active), 64'd0);
        checkOutput("s1_drop", 64'(drop_count), 64'd0);

        // Carry from nonce into time.
        doLoad(32'hAAAAAAA1, 32'hFFFFFFF0);
        idle(3, 0);
        for (int i = 0; i < LANES; i++) begin
            checkOutput("s2_c3_nonce", 64'(lane_nonce[32*i +: 32]), 64'(32'hFFFFFFFC + 32'(i)));
            checkOutput("s2_c3_time", 64'(lane_time[32*i +: 32]), 64'h0AAAAAAA1);
        end
        idle(1, 0);
        checkOutput("s2_c4_lane0", {lane_time[31:0], lane_nonce[31:0]}, 64'hAAAAAAA2_00000000);
        checkOutput("s2_c4_lane3", 64'(lane_nonce[127:96]), 64'h3);

        // Rollback of a single hit.
        doLoad(32'h130dae51, 32'h3aeb9bb0);
        idle(10, 0);
        applyStimulus(0, 0, 0, 0, 4'b0001, 0);
        checkOutput("s3_valid", 64'(sol_valid), 64'd1);
        checkOutput("s3_time", 64'(sol_time), 64'h130dae51);
        checkOutput("s3_nonce", 64'(sol_nonce), 64'h3aeb9bb8);
        checkOutput("s3_lane", 64'(sol_lane), 64'd0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        checkOutput("s3_popped", 64'(sol_valid), 64'd0);

        // Warm-up gating.
        doLoad(32'h130dae51, 32'h3aeb9bb0);
        idle(7, 0);
        applyStimulus(0, 0, 0, 0, 4'b1111, 0);
        checkOutput("s4_gated", 64'(sol_valid), 64'd0);
        applyStimulus(0, 0, 0, 0, 4'b1000, 0);
        checkOutput("s4_nonce", 64'(sol_nonce), 64'h3aeb9bb3);
        checkOutput("s4_drop", 64'(drop_count), 64'd0);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);

        // Multiple hits in one cycle.
        doLoad(32'h130dae51, 32'h3aeb9bb0);
        idle(8, 0);
        applyStimulus(0, 0, 0, 0, 4'b1010, 0);
        checkOutput("s5_lane", 64'(sol_lane), 64'd1);
        checkOutput("s5_nonce", 64'(sol_nonce), 64'h3aeb9bb1);
        checkOutput("s5_drop", 64'(drop_count), 64'd1);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);

        // FIFO full, ordering and push-on-pop while full.
        applyStimulus(1, 0, 0, 0, 4'b0000, 0);
        doLoad(32'h130dae51, 32'h3aeb9bb0);
        idle(8, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 4'b0001, 0);
        checkOutput("s6_drop", 64'(drop_count), 64'd1);
        checkOutput("s6_head0", 64'(sol_nonce), 64'h3aeb9bb0);
        applyStimulus(0, 0, 0, 0, 4'b0001, 1);
        checkOutput("s6_head1", 64'(sol_nonce), 64'h3aeb9bb4);
        checkOutput("s6_drop_kept", 64'(drop_count), 64'd1);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        checkOutput("s6_head2", 64'(sol_nonce), 64'h3aeb9bb8);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        checkOutput("s6_head3", 64'(sol_nonce), 64'h3aeb9bbc);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        checkOutput("s6_head4", 64'(sol_nonce), 64'h3aeb9bc4);
        applyStimulus(0, 0, 0, 0, 4'b0000, 1);
        checkOutput("s6_empty", 64'(sol_valid), 64'd0);

        // Saturation of drop_count plus the 64-bit wrap of the window.
        doLoad(32'hFFFFFFFF, 32'hFFFFFFF0);
        idle(8, 0);
        for (int i = 0; i < 80; i++) applyStimulus(0, 0, 0, 0, 4'b1111, 0);
        checkOutput("sat_drop", 64'(drop_count), 64'hFF);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] n;
            n = ($urandom % 2 == 1) ? ($urandom | 32'hFFFFFF00) : $urandom;
            applyStimulus(($urandom % 300) == 0, ($urandom % 40) == 0, $urandom, n,
                          ($urandom % 3 == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
